// File: rtl/ps2_packet_tx_if.sv
// Handshake bundle between a movement-report source, the PS/2 packet
// transmitter and its byte sink; master drives reports, slave is the transmitter.
interface ps2_packet_tx_if;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] dx;
    logic [9:0] dy;
    logic [2:0] btn;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       done;

    modport master (
        output load_valid, dx, dy, btn, out_ready,
        input  load_ready, out_byte, out_valid, done
    );

    modport slave (
        input  load_valid, dx, dy, btn, out_ready,
        output load_ready, out_byte, out_valid, done
    );
endinterface

// File: rtl/ps2_packet_tx.sv
// Serialises a movement report into a 3-byte PS/2 mouse packet with clamping.
// Optional macro PS2_TX_ACCUM_EN: accumulate reports arriving while busy.
module ps2_packet_tx #(
    parameter int unsigned GAP = 0
) (
    input  logic           clk,
    input  logic           resetn,
    ps2_packet_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BYTE1, BYTE2, BYTE3} state_e;

    localparam logic [3:0] GAP_L = 4'(GAP);

    // Clamp to -256..255 and return {ovf, sign, byte}.
    function automatic logic [9:0] clamp_axis(input logic signed [11:0] v);
        logic [9:0] r;
        if (v > 12'sd255) begin
            r = {1'b1, 1'b0, 8'hFF};
        end else if (v < -12'sd256) begin
            r = {1'b1, 1'b1, 8'h00};
        end else begin
            r = {1'b0, v[11], v[7:0]};
        end
        return r;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] pkt1_q, pkt1_d, pkt2_q, pkt2_d, pkt3_q, pkt3_d;
    logic [3:0] gap_q, gap_d;
    logic       done_q, done_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       ready_q, ready_d;
    logic       transfer_s, start_s;
    logic [11:0] src_x_s, src_y_s;
    logic [2:0] src_btn_s;
    logic [9:0] clamp_x_s, clamp_y_s;

    assign bus.load_ready = resetn & ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_byte   = out_byte_q;
    assign bus.done       = done_q;
    assign transfer_s     = out_valid_q & bus.out_ready;
    assign clamp_x_s      = clamp_axis(src_x_s);
    assign clamp_y_s      = clamp_axis(src_y_s);

`ifdef PS2_TX_ACCUM_EN
    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        logic [11:0] r;
        s = {a[11], a} + {b[11], b};
        case (s[12:11])
            2'b01:   r = 12'h7FF;
            2'b10:   r = 12'h800;
            default: r = s[11:0];
        endcase
        return r;
    endfunction

    logic [11:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [2:0]  acc_btn_q, acc_btn_d;
    logic        pend_q, pend_d;
    logic        accept_s, consume_s;

    assign accept_s  = bus.load_valid & bus.load_ready;
    assign consume_s = (state_q == IDLE) && (gap_q == 4'd0) && pend_q;
    assign start_s   = consume_s;
    assign src_x_s   = acc_x_q;
    assign src_y_s   = acc_y_q;
    assign src_btn_s = acc_btn_q;

    // Pending report: sum into a live report, restart when empty or being consumed.
    always_comb begin
        acc_x_d   = acc_x_q;
        acc_y_d   = acc_y_q;
        acc_btn_d = acc_btn_q;
        pend_d    = pend_q;
        if (accept_s) begin
            pend_d    = 1'b1;
            acc_btn_d = bus.btn;
            if (pend_q && !consume_s) begin
                acc_x_d = sat_add(acc_x_q, {{2{bus.dx[9]}}, bus.dx});
                acc_y_d = sat_add(acc_y_q, {{2{bus.dy[9]}}, bus.dy});
            end else begin
                acc_x_d = {{2{bus.dx[9]}}, bus.dx};
                acc_y_d = {{2{bus.dy[9]}}, bus.dy};
            end
        end else if (consume_s) begin
            pend_d    = 1'b0;
            acc_x_d   = 12'h000;
            acc_y_d   = 12'h000;
            acc_btn_d = 3'b000;
        end else begin
            pend_d = pend_q;
        end
    end

    // Pending report registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_x_q   <= 12'h000;
            acc_y_q   <= 12'h000;
            acc_btn_q <= 3'b000;
            pend_q    <= 1'b0;
        end else begin
            acc_x_q   <= acc_x_d;
            acc_y_q   <= acc_y_d;
            acc_btn_q <= acc_btn_d;
            pend_q    <= pend_d;
        end
    end
`else
    assign start_s   = bus.load_valid & bus.load_ready;
    assign src_x_s   = {{2{bus.dx[9]}}, bus.dx};
    assign src_y_s   = {{2{bus.dy[9]}}, bus.dy};
    assign src_btn_s = bus.btn;
`endif

    // Packet FSM: next state, packet capture, gap countdown and output decode.
    always_comb begin
        state_d = state_q;
        pkt1_d  = pkt1_q;
        pkt2_d  = pkt2_q;
        pkt3_d  = pkt3_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (start_s) begin
                    pkt1_d  = {clamp_y_s[9], clamp_x_s[9], clamp_y_s[8], clamp_x_s[8], 1'b1, src_btn_s};
                    pkt2_d  = clamp_x_s[7:0];
                    pkt3_d  = clamp_y_s[7:0];
                    state_d = BYTE1;
                end else begin
                    state_d = IDLE;
                end
            end
            BYTE1: begin
                if (transfer_s) state_d = BYTE2;
                else            state_d = BYTE1;
            end
            BYTE2: begin
                if (transfer_s) state_d = BYTE3;
                else            state_d = BYTE2;
            end
            BYTE3: begin
                if (transfer_s) begin
                    state_d = IDLE;
                    gap_d   = GAP_L;
                    done_d  = 1'b1;
                end else begin
                    state_d = BYTE3;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d != IDLE);
        case (state_d)
            BYTE1:   out_byte_d = pkt1_d;
            BYTE2:   out_byte_d = pkt2_d;
            BYTE3:   out_byte_d = pkt3_d;
            default: out_byte_d = 8'h00;
        endcase
`ifdef PS2_TX_ACCUM_EN
        ready_d = 1'b1;
`else
        ready_d = (state_d == IDLE) && (gap_d == 4'd0);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pkt1_q      <= 8'h00;
            pkt2_q      <= 8'h00;
            pkt3_q      <= 8'h00;
            gap_q       <= 4'd0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pkt1_q      <= pkt1_d;
            pkt2_q      <= pkt2_d;
            pkt3_q      <= pkt3_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            ready_q     <= ready_d;
        end
    end
endmodule

// File: tb/tb_ps2_packet_tx.sv
// Directed bench for ps2_packet_tx: encoding, clamping, back-pressure, reset and gap.
// Honours PS2_TX_ACCUM_EN (extra load latency and accumulation scenario).
module tb_ps2_packet_tx;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_pass;

    ps2_packet_tx_if bus1 ();
    ps2_packet_tx_if bus2 ();

    ps2_packet_tx #(.GAP(0)) u_dut  (.clk(clk), .resetn(resetn), .bus(bus1));
    ps2_packet_tx #(.GAP(2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    localparam logic [9:0] V_DX  [6] = '{10'd5,   10'h3FF, 10'd255, 10'd300, 10'd256, 10'h1FF};
    localparam logic [9:0] V_DY  [6] = '{10'h3FD, 10'd1,   10'h300, 10'h270, 10'h2FF, 10'h200};
    localparam logic [2:0] V_BTN [6] = '{3'b001,  3'b010,  3'b100,  3'b000,  3'b111,  3'b000};
    localparam logic [7:0] V_B1  [6] = '{8'h29,   8'h1A,   8'h2C,   8'hE8,   8'hEF,   8'hE8};
    localparam logic [7:0] V_B2  [6] = '{8'h05,   8'hFF,   8'hFF,   8'hFF,   8'hFF,   8'hFF};
    localparam logic [7:0] V_B3  [6] = '{8'hFD,   8'h01,   8'h00,   8'h00,   8'h00,   8'h00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        n_checks++; if (bus1.load_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus1.load_ready); else n_pass++;
        n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus1.out_valid); else n_pass++;
        n_checks++; if (bus1.out_byte !== 8'h00) $display("FAIL rst_byte: got %h want 00", bus1.out_byte); else n_pass++;
        n_checks++; if (bus1.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus1.done); else n_pass++;
        resetn = 1'b1;
        #1;
        n_checks++; if (bus1.load_ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", bus1.load_ready); else n_pass++;
    endtask

    task automatic test_encode();
        for (int i = 0; i < 6; i++) begin
            bus1.dx = V_DX[i]; bus1.dy = V_DY[i]; bus1.btn = V_BTN[i];
            bus1.load_valid = 1'b1;
            bus1.out_ready = 1'b1;
            n_checks++; if (bus1.load_ready !== 1'b1) $display("FAIL enc%0d_ready: got %b want 1", i, bus1.load_ready); else n_pass++;
            tick();
            bus1.load_valid = 1'b0;
`ifdef PS2_TX_ACCUM_EN
            n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL enc%0d_lat: got %b want 0", i, bus1.out_valid); else n_pass++;
            tick();
`endif
            n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== V_B1[i]) $display("FAIL enc%0d_b1: got %b/%h want 1/%h", i, bus1.out_valid, bus1.out_byte, V_B1[i]); else n_pass++;
            tick();
            n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== V_B2[i]) $display("FAIL enc%0d_b2: got %b/%h want 1/%h", i, bus1.out_valid, bus1.out_byte, V_B2[i]); else n_pass++;
            tick();
            n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== V_B3[i]) $display("FAIL enc%0d_b3: got %b/%h want 1/%h", i, bus1.out_valid, bus1.out_byte, V_B3[i]); else n_pass++;
            tick();
            n_checks++; if (bus1.out_valid !== 1'b0 || bus1.out_byte !== 8'h00) $display("FAIL enc%0d_idle: got %b/%h want 0/00", i, bus1.out_valid, bus1.out_byte); else n_pass++;
            n_checks++; if (bus1.done !== 1'b1) $display("FAIL enc%0d_done: got %b want 1", i, bus1.done); else n_pass++;
            n_checks++; if (bus1.load_ready !== 1'b1) $display("FAIL enc%0d_nogap: got %b want 1", i, bus1.load_ready); else n_pass++;
            tick();
            n_checks++; if (bus1.done !== 1'b0) $display("FAIL enc%0d_done_end: got %b want 0", i, bus1.done); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bus1.dx = 10'd5; bus1.dy = 10'h3FD; bus1.btn = 3'b001;
        bus1.load_valid = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        bus1.load_valid = 1'b0;
`ifdef PS2_TX_ACCUM_EN
        tick();
`endif
        tick();
        n_checks++; if (bus1.out_byte !== 8'h05) $display("FAIL bp_b2: got %h want 05", bus1.out_byte); else n_pass++;
        bus1.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== 8'h05) $display("FAIL bp_hold%0d: got %b/%h want 1/05", k, bus1.out_valid, bus1.out_byte); else n_pass++;
        end
        bus1.out_ready = 1'b1;
        tick();
        n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== 8'hFD) $display("FAIL bp_b3: got %b/%h want 1/FD", bus1.out_valid, bus1.out_byte); else n_pass++;
        tick();
        n_checks++; if (bus1.done !== 1'b1) $display("FAIL bp_done: got %b want 1", bus1.done); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bus1.dx = 10'd5; bus1.dy = 10'h3FD; bus1.btn = 3'b001;
        bus1.load_valid = 1'b1;
        bus1.out_ready = 1'b1;
        tick();
        bus1.load_valid = 1'b0;
`ifdef PS2_TX_ACCUM_EN
        tick();
`endif
        tick();
        n_checks++; if (bus1.out_byte !== 8'h05) $display("FAIL rm_b2: got %h want 05", bus1.out_byte); else n_pass++;
        resetn = 1'b0;
        tick();
        n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", bus1.out_valid); else n_pass++;
        n_checks++; if (bus1.load_ready !== 1'b0) $display("FAIL rm_ready_low: got %b want 0", bus1.load_ready); else n_pass++;
        resetn = 1'b1;
        #1;
        n_checks++; if (bus1.load_ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", bus1.load_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (bus1.done !== 1'b0 || bus1.out_valid !== 1'b0) $display("FAIL rm_quiet%0d: got %b/%b want 0/0", k, bus1.done, bus1.out_valid); else n_pass++;
        end
    endtask

    task automatic test_gap();
        bus2.dx = 10'd5; bus2.dy = 10'h3FD; bus2.btn = 3'b001;
        bus2.out_ready = 1'b1;
        bus2.load_valid = 1'b1;
`ifdef PS2_TX_ACCUM_EN
        n_checks++; if (bus2.load_ready !== 1'b1) $display("FAIL gap_ready: got %b want 1", bus2.load_ready); else n_pass++;
        tick();
        bus2.load_valid = 1'b0;
        tick();
        n_checks++; if (bus2.out_valid !== 1'b1 || bus2.out_byte !== 8'h29) $display("FAIL gap_b1: got %b/%h want 1/29", bus2.out_valid, bus2.out_byte); else n_pass++;
        n_checks++; if (bus2.load_ready !== 1'b1) $display("FAIL gap_busy_ready: got %b want 1", bus2.load_ready); else n_pass++;
`else
        tick();
        tick();
        tick();
        n_checks++; if (bus2.out_byte !== 8'hFD || bus2.load_ready !== 1'b0) $display("FAIL gap_b3: got %h/%b want FD/0", bus2.out_byte, bus2.load_ready); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++; if (bus2.load_ready !== 1'b0 || bus2.out_valid !== 1'b0) $display("FAIL gap_wait%0d: got %b/%b want 0/0", k, bus2.load_ready, bus2.out_valid); else n_pass++;
        end
        tick();
        n_checks++; if (bus2.load_ready !== 1'b1) $display("FAIL gap_open: got %b want 1", bus2.load_ready); else n_pass++;
        tick();
        bus2.load_valid = 1'b0;
        n_checks++; if (bus2.out_valid !== 1'b1 || bus2.out_byte !== 8'h29) $display("FAIL gap_next_b1: got %b/%h want 1/29", bus2.out_valid, bus2.out_byte); else n_pass++;
`endif
        for (int k = 0; k < 6; k++) tick();
    endtask

`ifdef PS2_TX_ACCUM_EN
    task automatic test_accum();
        bus1.out_ready = 1'b1;
        bus1.dx = 10'd5; bus1.dy = 10'h3FD; bus1.btn = 3'b001;
        bus1.load_valid = 1'b1;
        tick();
        bus1.load_valid = 1'b0;
        tick();
        n_checks++; if (bus1.out_byte !== 8'h29) $display("FAIL acc_first_b1: got %h want 29", bus1.out_byte); else n_pass++;
        bus1.dx = 10'd10; bus1.dy = 10'd0; bus1.btn = 3'b010;
        bus1.load_valid = 1'b1;
        tick();
        bus1.dx = 10'd20; bus1.btn = 3'b100;
        tick();
        bus1.load_valid = 1'b0;
        tick();
        n_checks++; if (bus1.done !== 1'b1) $display("FAIL acc_done: got %b want 1", bus1.done); else n_pass++;
        tick();
        n_checks++; if (bus1.out_valid !== 1'b1 || bus1.out_byte !== 8'h0C) $display("FAIL acc_b1: got %b/%h want 1/0C", bus1.out_valid, bus1.out_byte); else n_pass++;
        tick();
        n_checks++; if (bus1.out_byte !== 8'h1E) $display("FAIL acc_b2: got %h want 1E", bus1.out_byte); else n_pass++;
        tick();
        n_checks++; if (bus1.out_byte !== 8'h00) $display("FAIL acc_b3: got %h want 00", bus1.out_byte); else n_pass++;
        tick();
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        resetn = 1'b0;
        bus1.load_valid = 1'b0; bus1.dx = 10'd0; bus1.dy = 10'd0; bus1.btn = 3'b000; bus1.out_ready = 1'b0;
        bus2.load_valid = 1'b0; bus2.dx = 10'd0; bus2.dy = 10'd0; bus2.btn = 3'b000; bus2.out_ready = 1'b0;
        test_reset();
        test_encode();
        test_backpressure();
        test_reset_mid();
        test_gap();
`ifdef PS2_TX_ACCUM_EN
        test_accum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
